// File: rtl/e203_exu_flush_arb_pkg.sv
// Shared constants for the EXU flush arbiter: PC width, hart count, FSM encodings.
package e203_exu_flush_arb_pkg;

    localparam int unsigned E203_PC_SIZE  = 32;
    localparam int unsigned E203_HART_NUM = 2;

    // Arbiter FSM encodings (IDLE arbitrates, LOCK holds the granted hart).
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_LOCK = 1'b1;

endpackage

// File: rtl/e203_exu_flush_pick.sv
// Two-way flush winner picker: exception flushes beat ordinary flushes,
// ties go to the round-robin pointer. Purely combinational.
module e203_exu_flush_pick
    import e203_exu_flush_arb_pkg::*;
(
    input  logic [E203_HART_NUM-1:0] req_i,
    input  logic [E203_HART_NUM-1:0] excp_i,
    input  logic                     rr_i,
    output logic                     any_o,
    output logic                     win_o
);

    // Winner selection; with no request the pointer hart is reported
    always_comb begin
        any_o = |req_i;
        win_o = rr_i;
        case (req_i)
            2'b01:   win_o = 1'b0;
            2'b10:   win_o = 1'b1;
            2'b11:   win_o = (excp_i[0] != excp_i[1]) ? excp_i[1] : rr_i;
            default: win_o = rr_i;
        endcase
    end

endmodule

// File: rtl/e203_exu_flush_arb.sv
// Arbitrates per-hart flush requests onto the single shared IFU flush port.
// IDLE selects a winner in the same cycle; an unacked request locks the
// grant until it completes or the requester withdraws it.
module e203_exu_flush_arb
    import e203_exu_flush_arb_pkg::*;
#(
    parameter int unsigned PC_SIZE = E203_PC_SIZE,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [E203_HART_NUM-1:0]          hart_flush_req,
    input  logic [E203_HART_NUM-1:0]          hart_flush_excp,
    input  logic [E203_HART_NUM*PC_SIZE-1:0]  hart_flush_op1,
    input  logic [E203_HART_NUM*PC_SIZE-1:0]  hart_flush_op2,
    output logic [E203_HART_NUM-1:0]          hart_flush_ack,
    output logic                              pipe_flush_req,
    output logic [PC_SIZE-1:0]                pipe_flush_add_op1,
    output logic [PC_SIZE-1:0]                pipe_flush_add_op2,
    output logic                              pipe_flush_hart,
    input  logic                              pipe_flush_ack,
    output logic                              flush_pulse,
    output logic                              last_flush_hart,
    output logic [CNT_W-1:0]                  flush_cnt0,
    output logic [CNT_W-1:0]                  flush_cnt1
);

    logic             state_q, state_d;
    logic             gnt_q,   gnt_d;
    logic             rr_q,    rr_d;
    logic             last_q,  last_d;
    logic [CNT_W-1:0] cnt0_q,  cnt0_d;
    logic [CNT_W-1:0] cnt1_q,  cnt1_d;

    logic pick_any;
    logic pick_win;
    logic sel_hart;
    logic sel_req;
    logic pulse;

    e203_exu_flush_pick u_pick (
        .req_i  (hart_flush_req),
        .excp_i (hart_flush_excp),
        .rr_i   (rr_q),
        .any_o  (pick_any),
        .win_o  (pick_win)
    );

    // Selected hart and flush port drive; reset masks the request side
    always_comb begin
        sel_hart = (state_q == ST_LOCK) ? gnt_q : pick_win;
        sel_req  = (state_q == ST_LOCK) ? hart_flush_req[gnt_q] : pick_any;
        pipe_flush_req     = rst_n & sel_req;
        pulse              = pipe_flush_req & pipe_flush_ack;
        pipe_flush_hart    = sel_hart;
        pipe_flush_add_op1 = sel_hart ? hart_flush_op1[2*PC_SIZE-1:PC_SIZE]
                                      : hart_flush_op1[PC_SIZE-1:0];
        pipe_flush_add_op2 = sel_hart ? hart_flush_op2[2*PC_SIZE-1:PC_SIZE]
                                      : hart_flush_op2[PC_SIZE-1:0];
        hart_flush_ack     = {pulse & sel_hart, pulse & ~sel_hart};
        flush_pulse        = pulse;
    end

    // Next-state: lock on an unacked grant, release on completion or abort
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        last_d  = last_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any && !pipe_flush_ack) begin
                    state_d = ST_LOCK;
                    gnt_d   = pick_win;
                end
            end
            ST_LOCK: begin
                if (!hart_flush_req[gnt_q] || pipe_flush_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pulse) begin
            rr_d   = ~sel_hart;
            last_d = sel_hart;
            if (!sel_hart && (cnt0_q != {CNT_W{1'b1}})) begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end
            if (sel_hart && (cnt1_q != {CNT_W{1'b1}})) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
            last_q  <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign last_flush_hart = last_q;
    assign flush_cnt0      = cnt0_q;
    assign flush_cnt1      = cnt1_q;

endmodule

// File: doc/e203_exu_flush_arb.md
E203_EXU_FLUSH_ARB -- requirements
Module: e203_exu_flush_arb

Interface
REQ-001 SHALL have parameter PC_SIZE, default `E203_PC_SIZE (32), width of flush adder operands.
REQ-002 SHALL have parameter CNT_W, default 16, width of the per-hart flush counters.
REQ-003 clk  in  1  core clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 hart_flush_req  in  2  per-hart flush request, bit i = hart i; requester holds it until acked.
REQ-006 hart_flush_excp  in  2  per-hart flag: request is an exception/irq flush (1) or branch-mispredict/fence/mret flush (0).
REQ-007 hart_flush_op1  in  2*PC_SIZE  per-hart flush-PC adder operand 1, hart i in slice [i*PC_SIZE +: PC_SIZE].
REQ-008 hart_flush_op2  in  2*PC_SIZE  per-hart flush-PC adder operand 2, same slicing.
REQ-009 hart_flush_ack  out  2  per-hart flush acknowledge, one-cycle pulse.
REQ-010 pipe_flush_req  out  1  flush request to the shared IFU.
REQ-011 pipe_flush_add_op1  out  PC_SIZE  selected operand 1 to the IFU.
REQ-012 pipe_flush_add_op2  out  PC_SIZE  selected operand 2 to the IFU.
REQ-013 pipe_flush_hart  out  1  hart id of the current pipe_flush_req.
REQ-014 pipe_flush_ack  in  1  IFU accepts the flush.
REQ-015 flush_pulse  out  1  pipe_flush_req & pipe_flush_ack.
REQ-016 last_flush_hart  out  1  registered hart id of the most recently completed flush.
REQ-017 flush_cnt0, flush_cnt1  out  CNT_W each  saturating count of completed flushes per hart.

Function
REQ-018 The arbiter SHALL be a 2-state FSM: IDLE and LOCK, with registered grant gnt_r and round-robin pointer rr_r.
REQ-019 In IDLE, winner selection SHALL be combinational, same cycle: a requesting hart with excp=1 beats one with excp=0; on a tie, hart rr_r wins.
REQ-020 In IDLE with any request, pipe_flush_req SHALL be 1 in the same cycle (zero latency), with ops and pipe_flush_hart taken from the winner.
REQ-021 IDLE with handshake (req & ack) SHALL complete in that cycle, and the FSM SHALL stay IDLE; IDLE with req and no ack SHALL move to LOCK with gnt_r = winner.
REQ-022 In LOCK, the selection SHALL be frozen to gnt_r: pipe_flush_req = hart_flush_req[gnt_r], with no re-arbitration even if the other hart raises an excp request.
REQ-023 LOCK with handshake SHALL complete and return to IDLE.
REQ-024 LOCK with hart_flush_req[gnt_r] = 0 is an abort: return to IDLE, no ack, rr_r and counters unchanged.
REQ-025 hart_flush_ack[i] SHALL equal flush_pulse & (selected hart == i); at most one bit is set per cycle.
REQ-026 On completion, rr_r SHALL become ~(completed hart), last_flush_hart SHALL take the completed hart, and flush_cnt[hart] SHALL increment by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-027 With no request, pipe_flush_req SHALL be 0, and ops and pipe_flush_hart SHALL drive hart rr_r's values (don't-care, but deterministic).
REQ-028 pipe_flush_ack while pipe_flush_req = 0 SHALL be ignored.

Reset
REQ-029 While rst_n = 0 at a rising edge, the next state SHALL be: FSM IDLE, gnt_r 0, rr_r 0, last_flush_hart 0, counters 0.
REQ-030 While rst_n = 0, pipe_flush_req, hart_flush_ack and flush_pulse SHALL be forced 0 combinationally.
REQ-031 Reset asserted in LOCK SHALL drop the lock; no ack is issued for the pending flush.

Structure
REQ-032 PC_SIZE and the hart-count constant (2) SHALL come from e203_defines.v; the block SHALL add no new typedefs.
REQ-033 Winner selection SHALL be a sub-module e203_exu_flush_pick (2-way excp-priority, round-robin picker, combinational).
REQ-034 The block SHALL be 120-400 lines of RTL.

Verification
REQ-035 Single request: hart0 req, excp=0, op1=0x8000_0000, op2=0x10, ack held 1 -> pipe_flush_req=1 same cycle with those ops, hart_flush_ack=2'b01 that cycle, flush_cnt0=1, rr_r=1.
REQ-036 Priority: both request in IDLE, hart1 excp=1, hart0 excp=0, rr_r=0 -> hart1 granted; then hart0 granted next.
REQ-037 Round-robin fairness: both request, both excp=0, ack always 1, 6 cycles -> grants alternate 0,1,0,1,0,1 and each counter ends at 3.
REQ-038 Lock hold: hart0 granted with ack=0 for 3 cycles, hart1 raises excp=1 in cycle 2 -> pipe_flush_hart stays 0 until the cycle-4 ack, then hart1 granted.
REQ-039 Abort/reset/saturation:
- hart0 drops req in LOCK -> IDLE, no ack, counter unchanged.
- rst_n=0 during LOCK -> outputs 0, all state cleared.
- flush_cnt1 preloaded to 0xFFFF plus one more completion -> stays 0xFFFF.
